// File: rtl/ext_bus_sequencer.sv
// rtl/ext_bus_sequencer.sv - two-requester external memory bus sequencer (fetch vs load/store).
// Optional abort on a stuck bus_ready is enabled with `define BUS_TIMEOUT_EN.
module ext_bus_sequencer #(
  parameter int WAIT_STATES    = 1,
  parameter int STARVE_LIMIT   = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  output logic [7:0]  f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_ack,
  output logic [7:0]  d_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        bus_sel,
  output logic        bus_rd_en,
  output logic        bus_wr_en,
  input  logic        bus_ready,
  output logic        busy,
  output logic        timeout_err
);

`ifdef BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int         TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t        state, state_nx;
  logic [3:0]    wait_cnt;
  logic [3:0]    starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          lat_we;
  logic          grant_d, grant_f, complete, abort;
  logic          strobe_on;

  always_comb begin
    state_nx = state;
    grant_d  = 1'b0;
    grant_f  = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        // Data normally wins; a fetch starved for STARVE_LIMIT grants is forced through.
        if (d_req && !(f_req && (starve_cnt >= STARVE_LIM))) grant_d = 1'b1;
        else if (f_req)                                      grant_f = 1'b1;
        if (grant_d || grant_f) state_nx = SETUP;
      end
      SETUP:  state_nx = ACCESS;
      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          if (bus_ready) begin
            complete = 1'b1;
            state_nx = DONE;
          end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
            abort    = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      starve_cnt  <= 4'd0;
      tmo_cnt     <= '0;
      lat_we      <= 1'b0;
      bus_addr    <= 16'h0000;
      bus_wdata   <= 8'h00;
      bus_sel     <= 1'b0;
      f_rdata     <= 8'h00;
      d_rdata     <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_d) begin
        bus_addr <= d_addr;
        bus_sel  <= 1'b1;
        lat_we   <= d_we;
        if (d_we) bus_wdata <= d_wdata;
        if (f_req && (starve_cnt != 4'hF)) starve_cnt <= starve_cnt + 4'd1;
      end
      if (grant_f) begin
        bus_addr   <= f_addr;
        bus_sel    <= 1'b0;
        lat_we     <= 1'b0;
        starve_cnt <= 4'd0;
      end
      if (state == SETUP) begin
        wait_cnt <= WAIT_LOAD;
        tmo_cnt  <= '0;
      end
      if (state == ACCESS) begin
        if (wait_cnt != 4'd0)  wait_cnt <= wait_cnt - 4'd1;
        else if (!bus_ready)   tmo_cnt  <= tmo_cnt + 1'b1;
      end
      if (complete && !lat_we) begin
        if (bus_sel) d_rdata <= bus_rdata;
        else         f_rdata <= bus_rdata;
      end
      // An aborted read returns all-ones so software can spot the dead device.
      if (abort) begin
        timeout_err <= 1'b1;
        if (!lat_we) begin
          if (bus_sel) d_rdata <= 8'hFF;
          else         f_rdata <= 8'hFF;
        end
      end
    end
  end

  assign strobe_on = (state == SETUP) || (state == ACCESS);
  assign bus_rd_en = strobe_on && !lat_we;
  assign bus_wr_en = strobe_on && lat_we;
  assign f_ack     = (state == DONE) && !bus_sel;
  assign d_ack     = (state == DONE) && bus_sel;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// tb/tb_ext_bus_sequencer.sv - scoreboard bench for ext_bus_sequencer (honours BUS_TIMEOUT_EN).
module tb_ext_bus_sequencer;
  localparam int WS = 2;
  localparam int SL = 3;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_we;
  logic [15:0] f_addr, d_addr;
  logic [7:0]  d_wdata;
  logic        f_ack, d_ack;
  logic [7:0]  f_rdata, d_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        bus_sel, bus_rd_en, bus_wr_en, bus_ready, busy, timeout_err;

  always #5 clk = ~clk;

  ext_bus_sequencer #(.WAIT_STATES(WS), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_sel(bus_sel), .bus_rd_en(bus_rd_en), .bus_wr_en(bus_wr_en),
    .bus_ready(bus_ready), .busy(busy), .timeout_err(timeout_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Bus device: ROM for sel=0, RAM for sel=1; model_ram is the reference view of RAM.
  logic [7:0] rom [256];
  logic [7:0] dev_ram [256];
  logic [7:0] model_ram [256];
  int   rmode = 0;
  int   low_len = 0;
  int   age = 0;
  int   low_run = 0;
  logic rnd_ready = 1'b1;

  assign bus_rdata = bus_sel ? dev_ram[hx(bus_addr)] : rom[hx(bus_addr)];
  assign bus_ready = (rmode == 0) ? rnd_ready : (rmode == 1) ? (age >= low_len) : 1'b0;

  always @(posedge clk) begin
    age <= (bus_rd_en || bus_wr_en) ? age + 1 : 0;
    if (bus_wr_en && bus_ready) dev_ram[hx(bus_addr)] <= bus_wdata;
    if (low_run >= 2 || ($urandom % 4) != 0) begin
      rnd_ready <= 1'b1;
      low_run   <= 0;
    end else begin
      rnd_ready <= 1'b0;
      low_run   <= low_run + 1;
    end
  end

  typedef struct { bit we; logic [7:0] data; } dexp_t;
  logic [7:0] fq [$];
  dexp_t      dq [$];
  bit         order_q [$];
  logic [7:0] last_d = 8'h00;

  // Monitor: pops expectations whenever the DUT acknowledges.
  always @(negedge clk) begin
    if (rst) begin
      last_d <= 8'h00;
    end else begin
      if (bus_rd_en || bus_wr_en) check("strobe_excl", {63'd0, bus_rd_en & bus_wr_en}, 0);
      if (f_ack || d_ack)         check("ack_excl", {63'd0, f_ack & d_ack}, 0);
      if (f_ack) begin
        order_q.push_back(1'b0);
        if (fq.size() == 0) check("f_unexpected_ack", 1, 0);
        else begin
          check("f_rdata", {56'd0, f_rdata}, {56'd0, fq[0]});
          void'(fq.pop_front());
        end
      end
      if (d_ack) begin
        order_q.push_back(1'b1);
        if (dq.size() == 0) check("d_unexpected_ack", 1, 0);
        else begin
          if (dq[0].we) check("d_rdata_store_hold", {56'd0, d_rdata}, {56'd0, last_d});
          else begin
            check("d_rdata", {56'd0, d_rdata}, {56'd0, dq[0].data});
            last_d <= dq[0].data;
          end
          void'(dq.pop_front());
        end
      end
    end
  end

  function automatic int exp_c(input int low);
    return (low > WS + 1) ? low : WS + 1;
  endfunction

  task automatic issue(input bit port, input bit we, input logic [15:0] addr, input logic [7:0] wd,
                       input bit ff, output int lat, output int strobes);
    bit done;
    @(posedge clk); #1;
    if (!port) begin
      f_addr = addr;
      f_req  = 1'b1;
      fq.push_back(ff ? 8'hFF : rom[hx(addr)]);
    end else begin
      d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1;
      if (we) begin
        model_ram[hx(addr)] = wd;
        dq.push_back('{1'b1, wd});
      end else dq.push_back('{1'b0, ff ? 8'hFF : model_ram[hx(addr)]});
    end
    lat = 0; strobes = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if ((bus_sel == port) && (port && we ? (bus_wr_en && !bus_rd_en) : (bus_rd_en && !bus_wr_en)))
        strobes++;
      if (port ? d_ack : f_ack) done = 1'b1;
      else begin
        lat++;
        if (lat > 300) begin
          check("ack_bound", 64'(lat), 0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    if (!port) f_req = 1'b0; else d_req = 1'b0;
  endtask

  task automatic wait_acks(input bit port, input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (port ? d_ack : f_ack) got++;
    end
    if (got < n) check("hold_ack_bound", 64'(got), 64'(n));
    @(posedge clk); #1;
    if (!port) f_req = 1'b0; else d_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat, stb;
    logic [7:0] ord;
    rst = 1'b1; f_req = 0; d_req = 0; d_we = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom);
      dev_ram[i] = 8'($urandom);
      model_ram[i] = dev_ram[i];
    end
    rom[hx(16'h0100)] = 8'h3E;
    rom[hx(16'h0311)] = 8'h11;
    dev_ram[hx(16'h2000)] = 8'h5A;
    model_ram[hx(16'h2000)] = 8'h5A;
    #1;
    check("reset_outputs", {17'd0, bus_addr, bus_wdata, bus_sel, bus_rd_en, bus_wr_en, f_ack, d_ack,
                            f_rdata, d_rdata, busy, timeout_err}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch, ready high: ack at 3 + WS cycles, read strobe for 2 + WS cycles.
    rmode = 1; low_len = 0;
    issue(1'b0, 1'b0, 16'h0100, 8'h00, 1'b0, lat, stb);
    check("fetch_latency", 64'(lat), 64'(2 + exp_c(0)));
    check("fetch_strobes", 64'(stb), 64'(exp_c(0) + 1));

    // Store with ready held low for extra cycles, then read it back.
    low_len = WS + 1 + 3;
    issue(1'b1, 1'b1, 16'h8001, 8'hA5, 1'b0, lat, stb);
    check("store_latency", 64'(lat), 64'(2 + exp_c(low_len)));
    check("store_wr_strobes", 64'(stb), 64'(exp_c(low_len) + 1));
    low_len = 0;
    issue(1'b1, 1'b0, 16'h8001, 8'h00, 1'b0, lat, stb);
    check("store_readback_latency", 64'(lat), 64'(2 + exp_c(0)));

    // Load then fetch: d_rdata keeps the loaded byte.
    issue(1'b1, 1'b0, 16'h2000, 8'h00, 1'b0, lat, stb);
    issue(1'b0, 1'b0, 16'h0311, 8'h00, 1'b0, lat, stb);
    check("d_rdata_hold_after_fetch", {56'd0, d_rdata}, 64'h5A);
    check("f_rdata_after_fetch", {56'd0, f_rdata}, 64'h11);

    // Both requesters held continuously: every (SL+1)th grant goes to fetch.
    rmode = 0;
    order_q.delete();
    @(posedge clk); #1;
    f_addr = 16'h0042; d_we = 1'b0; d_addr = 16'h8005;
    for (int i = 0; i < 2; i++) fq.push_back(rom[hx(16'h0042)]);
    for (int i = 0; i < 6; i++) dq.push_back('{1'b0, model_ram[hx(16'h8005)]});
    f_req = 1'b1; d_req = 1'b1;
    fork
      wait_acks(1'b0, 2);
      wait_acks(1'b1, 6);
    join
    repeat (2) @(posedge clk);
    ord = 8'h00;
    for (int i = 0; i < 8 && i < order_q.size(); i++) ord = {ord[6:0], order_q[i]};
    check("grant_count", 64'(order_q.size()), 8);
    check("grant_order", {56'd0, ord}, 64'b11101110);

`ifdef BUS_TIMEOUT_EN
    check("timeout_err_clear", {63'd0, timeout_err}, 0);
    rmode = 2;
    issue(1'b0, 1'b0, 16'h0100, 8'h00, 1'b1, lat, stb);
    check("timeout_latency", 64'(lat), 64'(2 + WS + TO));
    check("timeout_strobes", 64'(stb), 64'(1 + WS + TO));
    check("timeout_err_set", {63'd0, timeout_err}, 1);
    rmode = 0;
`endif

    // Randomised concurrent traffic against the reference memories.
    fork
      begin
        int l1, s1;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom % 4) @(posedge clk);
          issue(1'b0, 1'b0, 16'($urandom), 8'h00, 1'b0, l1, s1);
        end
      end
      begin
        int l2, s2;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom % 4) @(posedge clk);
          issue(1'b1, 1'($urandom % 2), 16'h8000 + 16'($urandom_range(0, 7)), 8'($urandom), 1'b0, l2, s2);
        end
      end
    join
    check("fq_drained", 64'(fq.size()), 0);
    check("dq_drained", 64'(dq.size()), 0);
`ifdef BUS_TIMEOUT_EN
    check("timeout_err_sticky", {63'd0, timeout_err}, 1);
`endif

    // Reset in the middle of a stalled store: strobe drops at once, no ack, no write.
    rmode = 2;
    @(posedge clk); #1;
    d_we = 1'b1; d_addr = 16'h8003; d_wdata = ~model_ram[hx(16'h8003)]; d_req = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_before_reset", {62'd0, busy, bus_wr_en}, 3);
    #1 rst = 1'b1;
    #1;
    check("reset_mid_outputs", {17'd0, bus_addr, bus_wdata, bus_sel, bus_rd_en, bus_wr_en, f_ack, d_ack,
                                f_rdata, d_rdata, busy, timeout_err}, 0);
    d_req = 1'b0;
    lat = 0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack) lat++;
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack) lat++;
    end
    check("no_ack_after_reset", 64'(lat), 0);
    check("no_write_after_reset", {56'd0, dev_ram[hx(16'h8003)]}, {56'd0, model_ram[hx(16'h8003)]});
    check("idle_after_reset", {62'd0, busy, timeout_err}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
